// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Computes one result bit per cycle on unsigned magnitudes and fixes the sign
// on the final edge. Divide-by-zero and signed overflow finish at accept.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    request handshake (op/src1/src2 sampled on accept)
//   op                    funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   src1, src2            rs1 / rs2 operands
//   kill                  synchronous abort, highest priority
//   out_valid, out_ready  result handshake
//   result                registered result
module muldiv_unit #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DWIDTH-1:0] src1,
  input  logic [DWIDTH-1:0] src2,
  input  logic              kill,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(DWIDTH) + 1;
  localparam logic [DWIDTH-1:0] MinNeg = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [CntW-1:0] LastCnt = CntW'(DWIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [2:0]              op_q, op_d;
  logic                    neg1_q, neg1_d;
  logic                    neg2_q, neg2_d;
  // Multiplicand (multiply) or divisor (divide) magnitude.
  logic [DWIDTH-1:0]       opa_q, opa_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  logic [2*DWIDTH-1:0]     acc_q, acc_d;
  logic [DWIDTH-1:0]       result_q, result_d;

  // Accept-time decode.
  logic              signed1, signed2, neg1, neg2, div_zero, div_ovf, fast;
  logic [DWIDTH-1:0] mag1, mag2, fast_res;

  always_comb begin
    signed1 = 1'b0;
    signed2 = 1'b0;
    unique case (op)
      3'd0, 3'd1, 3'd4, 3'd6: begin signed1 = 1'b1; signed2 = 1'b1; end
      3'd2:                   signed1 = 1'b1;
      default:                ;
    endcase
    neg1     = signed1 & src1[DWIDTH-1];
    neg2     = signed2 & src2[DWIDTH-1];
    mag1     = neg1 ? -src1 : src1;
    mag2     = neg2 ? -src2 : src2;
    div_zero = op[2] && (src2 == '0);
    div_ovf  = op[2] && !op[0] && (src1 == MinNeg) && (&src2);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = op[1] ? src1 : '1;
    else          fast_res = op[1] ? '0 : src1;
  end

  // One iteration step.
  logic [DWIDTH:0]     mul_sum, rem_sh;
  logic [DWIDTH-1:0]   rem_diff;
  logic                rem_ge;
  logic [2*DWIDTH-1:0] mul_next, div_next, step_acc;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_next = {mul_sum, acc_q[DWIDTH-1:1]};
    rem_sh   = {acc_q[2*DWIDTH-1:DWIDTH], acc_q[DWIDTH-1]};
    rem_ge   = rem_sh >= {1'b0, opa_q};
    // When rem_ge holds the true difference is below the divisor, so it fits.
    rem_diff = rem_sh[DWIDTH-1:0] - opa_q;
    div_next = {(rem_ge ? rem_diff : rem_sh[DWIDTH-1:0]), acc_q[DWIDTH-2:0], rem_ge};
    step_acc = op_q[2] ? div_next : mul_next;
  end

  // Sign fix-up applied to the last iteration's output.
  logic [2*DWIDTH-1:0] prod_s;
  logic [DWIDTH-1:0]   quo, remd, calc_res;

  always_comb begin
    prod_s = (neg1_q ^ neg2_q) ? -step_acc : step_acc;
    quo    = step_acc[DWIDTH-1:0];
    remd   = step_acc[2*DWIDTH-1:DWIDTH];
    unique case (op_q)
      3'd0:             calc_res = prod_s[DWIDTH-1:0];
      3'd1, 3'd2, 3'd3: calc_res = prod_s[2*DWIDTH-1:DWIDTH];
      3'd4, 3'd5:       calc_res = (neg1_q ^ neg2_q) ? -quo : quo;
      default:          calc_res = neg1_q ? -remd : remd;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    opa_d    = opa_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (kill) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_d   = op;
            neg1_d = neg1;
            neg2_d = neg2;
            opa_d  = op[2] ? mag2 : mag1;
            acc_d  = {{DWIDTH{1'b0}}, (op[2] ? mag1 : mag2)};
            cnt_d  = '0;
            if (fast) begin
              state_d  = StDone;
              result_d = fast_res;
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d  = StDone;
            result_d = calc_res;
          end
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      opa_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      opa_q    <= opa_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table, multi-cycle corner sequences and
// randomized ops checked against an arithmetic reference model (DWIDTH = 32).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int n_pass = 0;
  int n_total = 0;
  bit ir_seen;

  muldiv_unit #(.DWIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // RV32M semantics from plain arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    int          sa, sb;
    longint      ps;
    logic [63:0] pu;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin ps = longint'(sa) * longint'(sb); return ps[31:0]; end
      3'd1: begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
      3'd2: begin ps = longint'(sa) * longint'({32'b0, b}); return ps[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Present a request and return after the accept edge (inputs then scrambled).
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); src1 = $urandom; src2 = $urandom;
  endtask

  // Count edges from the accept edge (=1) until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    ir_seen = in_ready;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) ir_seen = 1'b1;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat);
    start_op(o, a, b);
    wait_done(lat);
    r = result;
    handshake();
  endtask

  vec_t        vecs[12];
  logic [31:0] r, held;
  int          lat;

  initial begin
    vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};

    // Reset state.
    #12;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      if (i == 0) check("mul_in_ready_low", {31'b0, ir_seen}, 32'd0);
    end

    // Back-pressure: result and flags held while out_ready is low.
    start_op(3'd5, 32'd1000, 32'd9);
    wait_done(lat);
    held = result;
    check("bp_result", held, 32'd111);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_result", result, held);
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    handshake();
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    check("bp_release_valid", {31'b0, out_valid}, 32'd0);

    // Kill mid-divide, with in_valid asserted in the kill cycle.
    start_op(3'd5, 32'd123456, 32'd10);
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1; in_valid = 1'b1; op = 3'd0; src1 = 32'd3; src2 = 32'd3;
    @(posedge clk); #1;
    kill = 1'b0; in_valid = 1'b0;
    check("kill_in_ready", {31'b0, in_ready}, 32'd1);
    check("kill_out_valid", {31'b0, out_valid}, 32'd0);
    check("kill_result_kept", result, 32'd111);
    ir_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) ir_seen = 1'b1;
    end
    check("kill_no_valid", {31'b0, ir_seen}, 32'd0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    check("post_kill_mulhu", r, 32'hFFFF_FFFE);

    // Asynchronous reset mid-calculation.
    start_op(3'd0, 32'd1234, 32'd5678);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random operations against the reference model.
    for (int i = 0; i < 500; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      int          el;
      o = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: a = 32'h8000_0000;
        3: b = $urandom_range(0, 15);
        default: ;
      endcase
      do_op(o, a, b, r, lat);
      check($sformatf("rand%0d_op%0d_%08h_%08h", i, o, a, b), r, ref_model(o, a, b));
      el = (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(el));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
